like_alu: RTL and testbench

// - 5-bit, 4-function ALU (add, subtract, AND, OR) chosen by a 2-bit opcode.
// - Datapath leaf block; operands and opcode come from the control/register stage.
// - Result and status flags are registered once, giving a single-cycle latency.

---
 rtl/like_alu_if.sv | 31 +++
 rtl/like_alu.sv | 63 ++++++
 tb/tb_like_alu.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/like_alu_if.sv
// Operand/opcode/result bundle between the register stage and the like_alu datapath leaf.
// The ovf signal exists only when LIKE_ALU_OVF_EN is defined.
interface like_alu_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] InpA;
    logic [WIDTH-1:0] InpB;
    logic [1:0]       Select;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
`ifdef LIKE_ALU_OVF_EN
    logic             ovf;
`endif

    modport master (
        output InpA, InpB, Select,
`ifdef LIKE_ALU_OVF_EN
        input  ovf,
`endif
        input  out, carry, zero
    );

    modport slave (
        input  InpA, InpB, Select,
`ifdef LIKE_ALU_OVF_EN
        output ovf,
`endif
        output out, carry, zero
    );
endinterface

// File: rtl/like_alu.sv
// 4-function ALU (ADD/SUB/AND/OR) with registered result and flags, one-cycle latency.
// Define LIKE_ALU_OVF_EN to add a registered signed-overflow flag.
module like_alu #(
    parameter int WIDTH = 5
) (
    input  logic      clk,
    input  logic      reset,
    like_alu_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             cy;

    // Extra top bit gives carry on ADD and borrow (A < B) on SUB.
    assign sum  = {1'b0, bus.InpA} + {1'b0, bus.InpB};
    assign diff = {1'b0, bus.InpA} - {1'b0, bus.InpB};

    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (bus.Select)
            2'b00:   begin res = sum[MSB:0];  cy = sum[WIDTH];  end
            2'b01:   begin res = diff[MSB:0]; cy = diff[WIDTH]; end
            2'b10:   res = bus.InpA & bus.InpB;
            2'b11:   res = bus.InpA | bus.InpB;
            default: begin res = '0; cy = 1'b0; end
        endcase
    end

`ifdef LIKE_ALU_OVF_EN
    logic ov;
    always_comb begin
        ov = 1'b0;
        case (bus.Select)
            2'b00:   ov = (bus.InpA[MSB] == bus.InpB[MSB]) && (res[MSB] != bus.InpA[MSB]);
            2'b01:   ov = (bus.InpA[MSB] != bus.InpB[MSB]) && (res[MSB] != bus.InpA[MSB]);
            default: ov = 1'b0;
        endcase
    end
`endif

    // zero comes from the fresh result so it lines up with the out it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out   <= '0;
            bus.carry <= 1'b0;
            bus.zero  <= 1'b1;
`ifdef LIKE_ALU_OVF_EN
            bus.ovf   <= 1'b0;
`endif
        end else begin
            bus.out   <= res;
            bus.carry <= cy;
            bus.zero  <= (res == '0);
`ifdef LIKE_ALU_OVF_EN
            bus.ovf   <= ov;
`endif
        end
    end
endmodule

// File: tb/tb_like_alu.sv
// Scoreboard bench for like_alu: stimulus pushes integer-model expectations, a negedge monitor pops and compares.
module tb_like_alu;
    localparam int W = 5;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    like_alu_if #(.WIDTH(W)) bus ();
    like_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] o;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    exp_t q[$];

    function automatic int sgn(int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Plain integer arithmetic: unsigned result range gives carry/borrow, signed range gives overflow.
    function automatic exp_t model(int a, int b, int s);
        exp_t e;
        int r, sr;
        r = 0; sr = 0;
        e.c = 1'b0; e.v = 1'b0;
        case (s)
            0: begin r = a + b; e.c = (r >= M); sr = sgn(a) + sgn(b); end
            1: begin r = a - b; e.c = (a < b);  sr = sgn(a) - sgn(b); end
            2: r = a & b;
            default: r = a | b;
        endcase
        if (s < 2) e.v = (sr > M / 2 - 1) || (sr < -(M / 2));
        r = ((r % M) + M) % M;
        e.o = W'(r);
        e.z = (r == 0);
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e.o = '0; e.c = 1'b0; e.z = 1'b1; e.v = 1'b0;
        return e;
    endfunction

    task automatic chk(string name, exp_t e);
        logic v_act;
`ifdef LIKE_ALU_OVF_EN
        v_act = bus.ovf;
`else
        v_act = e.v;
`endif
        tests++;
        if (bus.out !== e.o || bus.carry !== e.c || bus.zero !== e.z || v_act !== e.v) begin
            fails++;
            $display("FAIL %s: got out=%b carry=%b zero=%b ovf=%b, expected out=%b carry=%b zero=%b ovf=%b",
                     name, bus.out, bus.carry, bus.zero, v_act, e.o, e.c, e.z, e.v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && q.size() > 0) chk("scoreboard", q.pop_front());
    end

    task automatic op(int a, int b, int s);
        @(negedge clk); #1;
        bus.InpA = W'(a); bus.InpB = W'(b); bus.Select = 2'(s);
        @(posedge clk);
        q.push_back(model(a, b, s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        exp_t held;
        // Reset with random inputs, before any clock edge.
        reset = 1'b1;
        bus.InpA = W'($urandom); bus.InpB = W'($urandom); bus.Select = 2'($urandom);
        #3 chk("reset_no_clk", rst_exp());
        @(negedge clk); reset = 1'b0;

        op(5'b00010, 5'b11100, 0);
        op(5'b10101, 5'b01101, 0);
`ifdef LIKE_ALU_OVF_EN
        op(5'b01000, 5'b01000, 0);
`endif
        op(5'b10001, 5'b01101, 1);
        op(5'b01101, 5'b10101, 1);
        op(5'b10101, 5'b10101, 1);
        op(5'b10101, 5'b01101, 2);
        op(5'b10101, 5'b01101, 3);
        op(5'b11111, 5'b00001, 0);
        op(5'b00000, 5'b00001, 1);
        op(5'b10000, 5'b00001, 1);

        // Latency: inputs change mid-cycle, out must hold until the next edge.
        op(21, 13, 0);
        held = model(21, 13, 0);
        @(negedge clk); #1;
        bus.InpA = 5'd3; bus.InpB = 5'd3; bus.Select = 2'd1;
        #2 chk("latency_hold", held);
        @(posedge clk);
        q.push_back(model(3, 3, 1));

        // Reset asserted between edges during an ADD sequence.
        op(7, 9, 0);
        op(30, 4, 0);
        #2 reset = 1'b1;
        q.delete();
        #1 chk("reset_mid_async", rst_exp());
        @(posedge clk); #1 chk("reset_held_edge", rst_exp());
        @(negedge clk); reset = 1'b0;
        op(12, 25, 0);

        for (int i = 0; i < 200; i++)
            op(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), int'($urandom_range(0, 3)));

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
